// File: rtl/cc1200_pkg.sv
// Shared CC1200 definitions: TX pixel buffer burst FSM states and default sizing.
package cc1200_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } txbuf_state_t;

    localparam int TXBUF_WIDTH      = 12;
    localparam int TXBUF_DEPTH      = 64;
    localparam int TXBUF_PKT_PIXELS = 32;

endpackage

// File: rtl/cc1200_sync_fifo.sv
// First-word-fall-through FIFO: storage array, wrapping pointers and occupancy level.
module cc1200_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic [AW:0]      level_next;

    // Storage is not reset; emptiness is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
        end
    end

    assign rd_data = (level_reg == '0) ? '0 : mem[rd_ptr_reg];
    assign level   = level_reg;

endmodule

// File: rtl/cc1200_tx_pixel_buf.sv
// CC1200 TX pixel buffer: FIFO plus burst/gap FSM feeding the SPI stage.
// Optional burst statistics counter enabled by CC1200_TXBUF_STATS_EN.
module cc1200_tx_pixel_buf
    import cc1200_pkg::*;
#(
    parameter int WIDTH      = TXBUF_WIDTH,
    parameter int DEPTH      = TXBUF_DEPTH,
    parameter int PKT_PIXELS = TXBUF_PKT_PIXELS,
    parameter int GAP_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     clr_flags,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     GetDataEn,
    output logic [WIDTH-1:0]         GetData,
    input  logic                     Next_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_flag,
    output logic                     err_flag,
    output logic [15:0]              pkt_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(PKT_PIXELS + 1);
    localparam int GW = $clog2(GAP_CYCLES);

    txbuf_state_t  state_reg, state_next;
    logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          get_data_en_reg;
    logic          ovf_flag_reg, err_flag_reg;
    logic          push, pop, burst_done, ovf_set, err_set;

    assign in_ready = (level != LW'(DEPTH));
    assign push     = in_valid && in_ready;

    cc1200_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (GetData),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            burst_cnt_reg   <= '0;
            gap_cnt_reg     <= '0;
            get_data_en_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            burst_cnt_reg   <= burst_cnt_next;
            gap_cnt_reg     <= gap_cnt_next;
            get_data_en_reg <= (state_next == BURST);
        end
    end

    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        if (flush) begin
            state_next     = IDLE;
            burst_cnt_next = '0;
            gap_cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (level >= LW'(PKT_PIXELS)) begin
                        state_next     = BURST;
                        burst_cnt_next = '0;
                    end
                end
                BURST: begin
                    if (pop) begin
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                        if (burst_done) begin
                            state_next   = GAP;
                            gap_cnt_next = '0;
                        end
                    end
                end
                GAP: begin
                    // GetDataEn stays low for exactly GAP_CYCLES cycles before re-arming
                    if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) begin
                        state_next = IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pop        = Next_data && (state_reg == BURST) && (level != '0);
        burst_done = pop && (burst_cnt_reg == BW'(PKT_PIXELS - 1));
        ovf_set    = in_valid && !in_ready;
        err_set    = Next_data && !pop;
        GetDataEn  = get_data_en_reg;
    end

    // A set condition outranks a coincident clr_flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_flag_reg <= 1'b0;
            err_flag_reg <= 1'b0;
        end else begin
            if (ovf_set)        ovf_flag_reg <= 1'b1;
            else if (clr_flags) ovf_flag_reg <= 1'b0;
            if (err_set)        err_flag_reg <= 1'b1;
            else if (clr_flags) err_flag_reg <= 1'b0;
        end
    end

    assign ovf_flag = ovf_flag_reg;
    assign err_flag = err_flag_reg;

`ifdef CC1200_TXBUF_STATS_EN
    logic [15:0] pkt_cnt_reg;
    logic        pkt_inc;

    assign pkt_inc = burst_done && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt_reg <= '0;
        end else if (clr_flags) begin
            pkt_cnt_reg <= {15'd0, pkt_inc};
        end else if (pkt_inc) begin
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_reg;
`else
    assign pkt_cnt = '0;
`endif

endmodule
